// File: rtl/gate_truth_checker.sv
// Truth-table sequencer for a 2-input gate: steps A/B through 00,01,10,11,
// samples y on the last dwell cycle of each vector and tallies mismatches.
module gate_truth_checker #(
    parameter int GATE_TYPE = 0,
    parameter int DWELL     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       y,
    output logic       A,
    output logic       B,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic       fail_valid,
    output logic [1:0] fail_vec
);

    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] LAST = DW'(DWELL - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nxt;
    logic [1:0]    vec, vec_nxt;
    logic [DW-1:0] dwell_cnt, dwell_nxt;
    logic [2:0]    err_nxt;
    logic          fv_nxt;
    logic [1:0]    fvec_nxt;
    logic          expected;
    logic          mismatch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            vec        <= 2'b00;
            dwell_cnt  <= '0;
            err_count  <= 3'd0;
            fail_valid <= 1'b0;
            fail_vec   <= 2'b00;
        end else begin
            state      <= state_nxt;
            vec        <= vec_nxt;
            dwell_cnt  <= dwell_nxt;
            err_count  <= err_nxt;
            fail_valid <= fv_nxt;
            fail_vec   <= fvec_nxt;
        end
    end

    // A vector is judged only on its final dwell cycle; y is ignored otherwise.
    always_comb begin
        state_nxt = state;
        vec_nxt   = vec;
        dwell_nxt = dwell_cnt;
        err_nxt   = err_count;
        fv_nxt    = fail_valid;
        fvec_nxt  = fail_vec;
        expected  = (GATE_TYPE == 0) ? ~(vec[1] | vec[0]) : ~(vec[1] & vec[0]);
        mismatch  = (y != expected);
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = RUN;
                    vec_nxt   = 2'b00;
                    dwell_nxt = '0;
                    err_nxt   = 3'd0;
                    fv_nxt    = 1'b0;
                    fvec_nxt  = 2'b00;
                end
            end
            RUN: begin
                if (dwell_cnt != LAST) begin
                    dwell_nxt = dwell_cnt + DW'(1);
                end else begin
                    if (mismatch) begin
                        err_nxt = err_count + 3'd1;
                        if (!fail_valid) begin
                            fv_nxt   = 1'b1;
                            fvec_nxt = vec;
                        end
                    end
                    if (vec == 2'b11) begin
                        state_nxt = DONE;
                    end else begin
                        vec_nxt   = vec + 2'b01;
                        dwell_nxt = '0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // pass is derived from the registered count, so a last-vector miss clears it.
    assign A    = vec[1];
    assign B    = vec[0];
    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign pass = done && (err_count == 3'd0);

endmodule

// File: tb/tb_gate_truth_checker.sv
// Directed bench: a NOR-expecting and a NAND-expecting checker are driven by
// behavioural gate models (good NOR, stuck-at-0, stuck-at-1, NAND).
module tb_gate_truth_checker;

    logic clk = 1'b0;
    logic rst_n;
    logic start;

    logic       y0, a0, b0, busy0, done0, pass0, fv0;
    logic [2:0] err0;
    logic [1:0] fvec0;
    logic       y1, a1, b1, busy1, done1, pass1, fv1;
    logic [2:0] err1;
    logic [1:0] fvec1;

    // 0 = good NOR, 1 = stuck-at-0, 2 = stuck-at-1, 3 = NAND
    int mode0;
    int mode1;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    gate_truth_checker #(.GATE_TYPE(0), .DWELL(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .y(y0),
        .A(a0), .B(b0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .fail_valid(fv0), .fail_vec(fvec0)
    );

    gate_truth_checker #(.GATE_TYPE(1), .DWELL(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .y(y1),
        .A(a1), .B(b1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_valid(fv1), .fail_vec(fvec1)
    );

    function automatic logic gateModel(input int m, input logic a, input logic b);
        case (m)
            0:       return ~(a | b);
            1:       return 1'b0;
            2:       return 1'b1;
            default: return ~(a & b);
        endcase
    endfunction

    always_comb y0 = gateModel(mode0, a0, b0);
    always_comb y1 = gateModel(mode1, a1, b1);

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives start for the first of n edges, then waits n edges and settles 1ns.
    task automatic applyStimulus(input logic s, input int n);
        start = s;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (n - 1) @(posedge clk);
        if (n > 1) #1;
    endtask

    task automatic waitEdges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        mode0 = 0;
        mode1 = 3;
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_ab",    {a0, b0}, 2'b00);
        checkOutput("rst_busy",  busy0, 1'b0);
        checkOutput("rst_done",  done0, 1'b0);
        checkOutput("rst_err",   err0, 3'd0);
        checkOutput("rst_fv",    {fv0, fvec0}, 3'b000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Test 1 (plus test 4 NAND on dut1): good gates, full sweep
        applyStimulus(1'b1, 1);
        checkOutput("t1_busy_e0", busy0, 1'b1);
        checkOutput("t1_ab_e0",   {a0, b0}, 2'b00);
        waitEdges(3);
        checkOutput("t1_ab_e3",   {a0, b0}, 2'b00);
        waitEdges(1);
        checkOutput("t1_ab_e4",   {a0, b0}, 2'b01);
        waitEdges(4);
        checkOutput("t1_ab_e8",   {a0, b0}, 2'b10);
        waitEdges(4);
        checkOutput("t1_ab_e12",  {a0, b0}, 2'b11);
        waitEdges(3);
        checkOutput("t1_done_e15", {busy0, done0}, 2'b10);
        waitEdges(1);
        checkOutput("t1_done_e16", {busy0, done0}, 2'b01);
        checkOutput("t1_pass",     pass0, 1'b1);
        checkOutput("t1_err",      err0, 3'd0);
        checkOutput("t1_fv",       fv0, 1'b0);
        checkOutput("t4_nand_pass", pass1, 1'b1);
        checkOutput("t4_nand_err",  err1, 3'd0);

        // Test 2: stuck-at-0 fails only 00
        mode0 = 1;
        applyStimulus(1'b1, 17);
        checkOutput("t2_done", done0, 1'b1);
        checkOutput("t2_err",  err0, 3'd1);
        checkOutput("t2_fv",   {fv0, fvec0}, 3'b100);
        checkOutput("t2_pass", pass0, 1'b0);

        // Test 3: stuck-at-1 fails 01,10,11 including the final vector
        mode0 = 2;
        applyStimulus(1'b1, 13);
        checkOutput("t3_err_e12", err0, 3'd2);
        waitEdges(4);
        checkOutput("t3_err",  err0, 3'd3);
        checkOutput("t3_fv",   {fv0, fvec0}, 3'b101);
        checkOutput("t3_pass", {done0, pass0}, 2'b10);

        // Test 4: NAND into the NOR checker differs at 01 and 10
        mode0 = 3;
        applyStimulus(1'b1, 17);
        checkOutput("t4_err",  err0, 3'd2);
        checkOutput("t4_fv",   {fv0, fvec0}, 3'b101);
        checkOutput("t4_pass", pass0, 1'b0);

        // Test 5: start mid-sweep ignored; start in DONE restarts cleanly
        mode0 = 2;
        applyStimulus(1'b1, 6);
        start = 1'b1;
        waitEdges(1);
        start = 1'b0;
        checkOutput("t5_ab_e6",    {a0, b0}, 2'b01);
        checkOutput("t5_busy_e6",  busy0, 1'b1);
        waitEdges(9);
        checkOutput("t5_done_e15", done0, 1'b0);
        waitEdges(1);
        checkOutput("t5_done_e16", done0, 1'b1);
        checkOutput("t5_err",      err0, 3'd3);
        mode0 = 0;
        applyStimulus(1'b1, 1);
        checkOutput("t5_restart",  {busy0, done0, pass0}, 3'b100);
        checkOutput("t5_clr_err",  err0, 3'd0);
        checkOutput("t5_clr_fv",   {fv0, fvec0}, 3'b000);
        checkOutput("t5_ab",       {a0, b0}, 2'b00);

        // Test 6: asynchronous reset between edges 9 and 10
        waitEdges(8);
        checkOutput("t6_ab_e8", {a0, b0}, 2'b10);
        waitEdges(1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_ab",   {a0, b0}, 2'b00);
        checkOutput("t6_rst_busy", {busy0, done0, pass0}, 3'b000);
        checkOutput("t6_rst_err",  {err0, fv0, fvec0}, 6'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("t6_idle", {busy0, done0}, 2'b00);
        applyStimulus(1'b1, 17);
        checkOutput("t6_done", {busy0, done0, pass0}, 3'b011);
        checkOutput("t6_err",  {err0, fv0}, 4'd0);
        checkOutput("t6_nand", pass1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
